// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite responder backed by a word-addressed on-chip memory.
// Independent write (AW/W/B) and read (AR/R) channels, one outstanding transaction each.
module axi_lite_mem_responder #(
  parameter int unsigned               DataWidth    = 32,
  parameter int unsigned               AddressWidth = 32,
  parameter int unsigned               Depth        = 1024,
  parameter logic [AddressWidth-1:0]   AddrBase     = AddressWidth'(32'h40000)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      awvalid_i,
  output logic                      awready_o,
  input  logic [AddressWidth-1:0]   awaddr_i,
  input  logic                      wvalid_i,
  output logic                      wready_o,
  input  logic [DataWidth-1:0]      wdata_i,
  input  logic [DataWidth/8-1:0]    wstrb_i,
  output logic                      bvalid_o,
  input  logic                      bready_i,
  output logic [1:0]                bresp_o,
  input  logic                      arvalid_i,
  output logic                      arready_o,
  input  logic [AddressWidth-1:0]   araddr_i,
  output logic                      rvalid_o,
  input  logic                      rready_i,
  output logic [DataWidth-1:0]      rdata_o,
  output logic [1:0]                rresp_o
);

  localparam int unsigned             StrbWidth = DataWidth / 8;
  localparam int unsigned             IdxWidth  = $clog2(Depth);
  localparam logic [AddressWidth-1:0] DepthA    = AddressWidth'(Depth);
  localparam logic [1:0]              RespOkay  = 2'b00;
  localparam logic [1:0]              RespSlvErr = 2'b10;

  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  // Addresses below AddrBase wrap to a huge offset, so the explicit >= test is belt and braces.
  function automatic logic addr_in_range(input logic [AddressWidth-1:0] addr);
    return (addr >= AddrBase) && (((addr - AddrBase) >> 2) < DepthA);
  endfunction

  function automatic logic [IdxWidth-1:0] addr_idx(input logic [AddressWidth-1:0] addr);
    return IdxWidth'((addr - AddrBase) >> 2);
  endfunction

  logic [DataWidth-1:0]    mem [Depth];

  logic                    aw_full_q, aw_full_d;
  logic [AddressWidth-1:0] aw_addr_q, aw_addr_d;
  logic                    w_full_q,  w_full_d;
  logic [DataWidth-1:0]    w_data_q,  w_data_d;
  logic [StrbWidth-1:0]    w_strb_q,  w_strb_d;
  logic                    b_valid_q, b_valid_d;
  logic [1:0]              b_resp_q,  b_resp_d;
  r_state_e                r_state_q, r_state_d;
  logic [DataWidth-1:0]    r_data_q,  r_data_d;
  logic [1:0]              r_resp_q,  r_resp_d;

  logic commit;
  logic wr_in_range;
  logic ar_hs;
  logic rd_in_range;

  assign awready_o = ~aw_full_q;
  assign wready_o  = ~w_full_q;
  assign bvalid_o  = b_valid_q;
  assign bresp_o   = b_resp_q;
  assign arready_o = (r_state_q == R_IDLE) | rready_i;
  assign rvalid_o  = (r_state_q == R_RESP);
  assign rdata_o   = r_data_q;
  assign rresp_o   = r_resp_q;

  // A B slot being drained this cycle counts as free, so commits can run back to back.
  always_comb begin
    commit      = aw_full_q & w_full_q & (~b_valid_q | bready_i);
    wr_in_range = addr_in_range(aw_addr_q);
    aw_full_d   = aw_full_q;
    aw_addr_d   = aw_addr_q;
    w_full_d    = w_full_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    b_valid_d   = b_valid_q;
    b_resp_d    = b_resp_q;

    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      b_valid_d = 1'b1;
      b_resp_d  = wr_in_range ? RespOkay : RespSlvErr;
    end else if (bready_i) begin
      b_valid_d = 1'b0;
    end

    if (awvalid_i && !aw_full_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = awaddr_i;
    end
    if (wvalid_i && !w_full_q) begin
      w_full_d = 1'b1;
      w_data_d = wdata_i;
      w_strb_d = wstrb_i;
    end
  end

  // The memory is sampled before the edge, so a same-cycle commit is seen as read-before-write.
  always_comb begin
    ar_hs       = arvalid_i & arready_o;
    rd_in_range = addr_in_range(araddr_i);
    r_state_d   = r_state_q;
    r_data_d    = r_data_q;
    r_resp_d    = r_resp_q;

    if (ar_hs) begin
      r_state_d = R_RESP;
      r_data_d  = rd_in_range ? mem[addr_idx(araddr_i)] : '0;
      r_resp_d  = rd_in_range ? RespOkay : RespSlvErr;
    end else if (rready_i) begin
      r_state_d = R_IDLE;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RespOkay;
      r_state_q <= R_IDLE;
      r_data_q  <= '0;
      r_resp_q  <= RespOkay;
    end else begin
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      r_state_q <= r_state_d;
      r_data_q  <= r_data_d;
      r_resp_q  <= r_resp_d;
    end
  end

  // NOTE: the memory array has no reset so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (commit && wr_in_range) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (w_strb_q[b]) begin
          mem[addr_idx(aw_addr_q)][8*b +: 8] <= w_data_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed bench for axi_lite_mem_responder: a transaction-level model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_axi_lite_mem_responder;

  localparam logic [31:0] BASE  = 32'h40000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  axi_lite_mem_responder dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .awvalid_i (awvalid),
    .awready_o (awready),
    .awaddr_i  (awaddr),
    .wvalid_i  (wvalid),
    .wready_o  (wready),
    .wdata_i   (wdata),
    .wstrb_i   (wstrb),
    .bvalid_o  (bvalid),
    .bready_i  (bready),
    .bresp_o   (bresp),
    .arvalid_i (arvalid),
    .arready_o (arready),
    .araddr_i  (araddr),
    .rvalid_o  (rvalid),
    .rready_i  (rready),
    .rdata_o   (rdata),
    .rresp_o   (rresp)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: holds, one B slot, one R slot, sparse word memory.
  bit          m_aw_full, m_w_full, m_bvalid, m_rvalid, m_rknown;
  logic [31:0] m_aw_addr, m_w_data, m_rdata;
  logic [3:0]  m_w_strb;
  logic [1:0]  m_bresp, m_rresp;
  logic [31:0] mmem [logic [31:0]];

  function automatic bit in_rng(input logic [31:0] a);
    longint x;
    x = longint'(a);
    return (x >= longint'(BASE)) && (x < longint'(BASE) + 4 * DEPTH);
  endfunction

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_aw_full = 0; m_w_full = 0; m_bvalid = 0; m_rvalid = 0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = '0; m_rknown = 1;
    end else begin : model_step
      bit          aw_hs, w_hs, ar_hs, commit;
      logic [31:0] word;
      aw_hs  = awvalid && !m_aw_full;
      w_hs   = wvalid && !m_w_full;
      ar_hs  = arvalid && (!m_rvalid || rready);
      commit = m_aw_full && m_w_full && (!m_bvalid || bready);
      if (ar_hs) begin
        m_rvalid = 1;
        if (in_rng(araddr)) begin
          m_rresp  = 2'b00;
          m_rknown = mmem.exists(araddr >> 2);
          m_rdata  = m_rknown ? mmem[araddr >> 2] : '0;
        end else begin
          m_rresp = 2'b10; m_rdata = '0; m_rknown = 1;
        end
      end else if (rready) begin
        m_rvalid = 0;
      end
      if (commit) begin
        if (in_rng(m_aw_addr)) begin
          if (mmem.exists(m_aw_addr >> 2)) begin
            word = mmem[m_aw_addr >> 2];
            for (int b = 0; b < 4; b++) if (m_w_strb[b]) word[8*b +: 8] = m_w_data[8*b +: 8];
            mmem[m_aw_addr >> 2] = word;
          end else if (m_w_strb == 4'hF) begin
            mmem[m_aw_addr >> 2] = m_w_data;
          end
        end
        m_bvalid = 1; m_bresp = in_rng(m_aw_addr) ? 2'b00 : 2'b10;
        m_aw_full = 0; m_w_full = 0;
      end else if (bready) begin
        m_bvalid = 0;
      end
      if (aw_hs) begin m_aw_full = 1; m_aw_addr = awaddr; end
      if (w_hs)  begin m_w_full = 1; m_w_data = wdata; m_w_strb = wstrb; end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("m_awready", awready, !m_aw_full);
      check("m_wready",  wready,  !m_w_full);
      check("m_arready", arready, !m_rvalid || rready);
      check("m_bvalid",  bvalid,  m_bvalid);
      check("m_rvalid",  rvalid,  m_rvalid);
      if (m_bvalid) check("m_bresp", bresp, m_bresp);
      if (m_rvalid) begin
        check("m_rresp", rresp, m_rresp);
        if (m_rknown) check("m_rdata", rdata, m_rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] exp_resp);
    int i = 0;
    while (!(awready && wready) && i < 20) begin tick(); i++; end
    check("wr_idle_ready", awready && wready, 1);
    awvalid = 1; wvalid = 1; awaddr = a; wdata = d; wstrb = s; bready = 1;
    tick();
    awvalid = 0; wvalid = 0;
    check("wr_commit_cycle_bvalid", bvalid, 0);
    tick();
    check("wr_bvalid_lat2", bvalid, 1);
    check("wr_bresp", bresp, exp_resp);
    tick();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
    int i = 0;
    rready = 1;
    while (!arready && i < 20) begin tick(); i++; end
    check("rd_arready", arready, 1);
    arvalid = 1; araddr = a;
    tick();
    arvalid = 0;
    check("rd_rvalid_lat1", rvalid, 1);
    check("rd_rdata", rdata, exp_d);
    check("rd_rresp", rresp, exp_r);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", awready, 1);
    check("rst_wready",  wready,  1);
    check("rst_arready", arready, 1);
    check("rst_bvalid",  bvalid,  0);
    check("rst_rvalid",  rvalid,  0);
    check("rst_bresp",   bresp,   0);
    check("rst_rresp",   rresp,   0);
    check("rst_rdata",   rdata,   0);
    rst_n = 1;
    tick();

    // Basic full-word write and readback.
    wr(32'h40004, 32'hDEADBEEF, 4'hF, 2'b00);
    rd(32'h40004, 32'hDEADBEEF, 2'b00);

    // W arrives two cycles before AW: no commit until AW, then a single-byte merge.
    wr(32'h40008, 32'h11223344, 4'hF, 2'b00);
    wvalid = 1; wdata = 32'h0000AA00; wstrb = 4'b0010; bready = 1;
    tick();
    wvalid = 0;
    for (int k = 0; k < 2; k++) begin
      check("wfirst_awready", awready, 1);
      check("wfirst_wready",  wready,  0);
      check("wfirst_bvalid",  bvalid,  0);
      if (k == 0) tick();
    end
    awvalid = 1; awaddr = 32'h40008;
    tick();
    awvalid = 0;
    check("wfirst_commit_bvalid", bvalid, 0);
    tick();
    check("wfirst_bvalid", bvalid, 1);
    check("wfirst_bresp",  bresp,  2'b00);
    tick();
    rd(32'h40008, 32'h1122AA44, 2'b00);

    // Zero strobes leave memory alone but still answer OKAY.
    wr(32'h40004, 32'h00000000, 4'h0, 2'b00);
    rd(32'h40004, 32'hDEADBEEF, 2'b00);

    // Out-of-range on both sides of the window.
    wr(32'h3FFFC, 32'hCAFEF00D, 4'hF, 2'b10);
    wr(BASE + 4 * DEPTH, 32'hCAFEF00D, 4'hF, 2'b10);
    rd(32'h41000, 32'h00000000, 2'b10);
    rd(32'h3FFFC, 32'h00000000, 2'b10);
    rd(32'h40004, 32'hDEADBEEF, 2'b00);

    // B backpressure: second write held until the first response drains.
    bready = 0;
    awvalid = 1; wvalid = 1; awaddr = 32'h40010; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    check("bp_first_bvalid", bvalid, 1);
    check("bp_first_bresp",  bresp,  2'b00);
    awvalid = 1; wvalid = 1; awaddr = 32'h41004; wdata = 32'h5A5A5A5A;
    tick();
    awvalid = 0; wvalid = 0;
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_bvalid",  bvalid,  1);
      check("bp_hold_bresp",   bresp,   2'b00);
      check("bp_hold_awready", awready, 0);
      check("bp_hold_wready",  wready,  0);
      tick();
    end
    bready = 1;
    tick();
    check("bp_second_bvalid", bvalid, 1);
    check("bp_second_bresp",  bresp,  2'b10);
    tick();
    check("bp_drained_bvalid", bvalid, 0);
    rd(32'h40010, 32'hA5A5A5A5, 2'b00);

    // Back-to-back reads, then R backpressure.
    wr(32'h40000, 32'h01020304, 4'hF, 2'b00);
    rready = 1; arvalid = 1; araddr = 32'h40000;
    tick();
    check("b2b_0", rdata, 32'h01020304);
    araddr = 32'h40004;
    tick();
    check("b2b_1", rdata, 32'hDEADBEEF);
    araddr = 32'h40008;
    tick();
    check("b2b_2", rdata, 32'h1122AA44);
    check("b2b_rvalid", rvalid, 1);
    arvalid = 0;
    tick();
    check("b2b_end_rvalid", rvalid, 0);
    rready = 0; arvalid = 1; araddr = 32'h40000;
    tick();
    araddr = 32'h40004;
    for (int k = 0; k < 3; k++) begin
      check("rbp_arready", arready, 0);
      check("rbp_rvalid",  rvalid,  1);
      check("rbp_rdata",   rdata,   32'h01020304);
      tick();
    end
    rready = 1;
    tick();
    check("rbp_next_rdata", rdata, 32'hDEADBEEF);
    arvalid = 0;
    tick();
    check("rbp_end_rvalid", rvalid, 0);

    // Same-cycle read and commit to one word: read-before-write.
    wr(32'h40010, 32'h00000001, 4'hF, 2'b00);
    awvalid = 1; wvalid = 1; awaddr = 32'h40010; wdata = 32'h00000002; wstrb = 4'hF; bready = 1;
    tick();
    awvalid = 0; wvalid = 0;
    arvalid = 1; araddr = 32'h40010; rready = 1;
    tick();
    arvalid = 0;
    check("rbw_rdata",  rdata,  32'h00000001);
    check("rbw_bvalid", bvalid, 1);
    tick();
    rd(32'h40010, 32'h00000002, 2'b00);

    // Reset while a B and an R response are both pending.
    bready = 0; rready = 0;
    awvalid = 1; wvalid = 1; awaddr = 32'h40018; wdata = 32'h00000007;
    arvalid = 1; araddr = 32'h40004;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    tick();
    check("prerst_bvalid", bvalid, 1);
    check("prerst_rvalid", rvalid, 1);
    #2 rst_n = 0;
    #1;
    check("async_rst_bvalid", bvalid, 0);
    check("async_rst_rvalid", rvalid, 0);
    check("async_rst_rdata",  rdata,  0);
    tick();
    rst_n = 1;
    check("post_rst_awready", awready, 1);
    check("post_rst_wready",  wready,  1);
    check("post_rst_arready", arready, 1);
    bready = 1;
    tick();
    rd(32'h40018, 32'h00000007, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
